qr_result_collector: RTL

//  Receive side of the QR_top output stream: captures rows presented on valid/data_out*,

---
 rtl/qr_pkg.sv | 21 ++
 rtl/qr_row_buffer.sv | 27 ++
 rtl/qr_result_collector.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/qr_pkg.sv
// Shared types and sizing for the QR result collector: lane word, row, and FSM states.
// Lane 0 of a row is A and lane 3 is D.
package qr_pkg;

    localparam int DATA_W = 13;
    localparam int LANES  = 4;
    localparam int ROWS   = 8;
    localparam int IDX_W  = $clog2(ROWS);
    localparam int CNT_W  = $clog2(ROWS) + 1;

    typedef logic signed [DATA_W-1:0] word_t;
    typedef word_t [LANES-1:0]        row_t;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        DRAIN,
        DONE
    } coll_state_t;

endpackage

// File: rtl/qr_row_buffer.sv
// Row storage for one R-matrix result: one write port and one asynchronous read port.
// Storage has no reset, so its contents after reset are undefined.
module qr_row_buffer
    import qr_pkg::*;
#(
    parameter int DEPTH = ROWS,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  row_t          wdata_i,
    input  logic [AW-1:0] raddr_i,
    output row_t          rdata_o
);

    row_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/qr_result_collector.sv
// Captures one QR_top result (up to ROWS rows), then drains it row by row over valid/ready.
// The FSM, the counters and the sticky error flags live here; row storage is in qr_row_buffer.
module qr_result_collector
    import qr_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_dataA,
    input  logic [DATA_W-1:0] in_dataB,
    input  logic [DATA_W-1:0] in_dataC,
    input  logic [DATA_W-1:0] in_dataD,
    input  logic              in_finish,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_dataA,
    output logic [DATA_W-1:0] rd_dataB,
    output logic [DATA_W-1:0] rd_dataC,
    output logic [DATA_W-1:0] rd_dataD,
    output logic              rd_last,
    output logic [IDX_W-1:0]  rd_index,
    output logic [CNT_W-1:0]  row_count,
    output logic              done,
    output logic              overflow,
    output logic              drop_err
);

    coll_state_t      state_q, state_d;
    logic [CNT_W-1:0] row_count_q, row_count_d;
    logic [IDX_W-1:0] rd_index_q, rd_index_d;
    logic             rd_valid_q, rd_valid_d;
    row_t             rd_data_q, rd_data_d;
    logic             overflow_q, overflow_d;
    logic             drop_err_q, drop_err_d;

    logic             we;
    logic [IDX_W-1:0] waddr;
    logic [IDX_W-1:0] raddr;
    row_t             wdata;
    row_t             rdata;
    logic             hs;
    logic             last;
    logic             load_first;

    always_comb begin
        wdata    = '0;
        wdata[0] = in_dataA;
        wdata[1] = in_dataB;
        wdata[2] = in_dataC;
        wdata[3] = in_dataD;
    end

    qr_row_buffer #(
        .DEPTH (ROWS),
        .AW    (IDX_W)
    ) u_buf (
        .clk     (clk),
        .we_i    (we),
        .waddr_i (waddr),
        .wdata_i (wdata),
        .raddr_i (raddr),
        .rdata_o (rdata)
    );

    assign hs   = rd_valid_q && rd_ready;
    assign last = rd_valid_q && ({1'b0, rd_index_q} == (row_count_q - CNT_W'(1)));

    always_comb begin
        state_d     = state_q;
        row_count_d = row_count_q;
        rd_index_d  = rd_index_q;
        rd_valid_d  = rd_valid_q;
        rd_data_d   = rd_data_q;
        overflow_d  = overflow_q;
        drop_err_d  = drop_err_q;
        we          = 1'b0;
        waddr       = row_count_q[IDX_W-1:0];
        raddr       = rd_index_q;
        load_first  = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    we          = 1'b1;
                    waddr       = '0;
                    row_count_d = CNT_W'(1);
                    state_d     = in_finish ? DRAIN : CAPTURE;
                    load_first  = in_finish;
                end else if (in_finish) begin
                    state_d = DONE;
                end
            end
            CAPTURE: begin
                if (in_valid) begin
                    if (row_count_q < CNT_W'(ROWS)) begin
                        we          = 1'b1;
                        row_count_d = row_count_q + CNT_W'(1);
                    end else begin
                        overflow_d = 1'b1;
                    end
                end
                if (in_finish) begin
                    state_d    = DRAIN;
                    load_first = 1'b1;
                end
            end
            DRAIN: begin
                if (in_valid) begin
                    drop_err_d = 1'b1;
                end
                if (hs) begin
                    if (last) begin
                        rd_valid_d = 1'b0;
                        state_d    = DONE;
                    end else begin
                        rd_index_d = rd_index_q + 1'b1;
                        raddr      = rd_index_q + 1'b1;
                        rd_data_d  = rdata;
                    end
                end
            end
            DONE: begin
                if (in_valid) begin
                    drop_err_d = 1'b1;
                end
                rd_index_d  = '0;
                row_count_d = '0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Row 0 may be written on the same edge that finish is accepted, so forward it.
        if (load_first) begin
            raddr      = '0;
            rd_index_d = '0;
            rd_valid_d = 1'b1;
            rd_data_d  = (we && (waddr == raddr)) ? wdata : rdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            row_count_q <= '0;
            rd_index_q  <= '0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            overflow_q  <= 1'b0;
            drop_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_count_q <= row_count_d;
            rd_index_q  <= rd_index_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
            overflow_q  <= overflow_d;
            drop_err_q  <= drop_err_d;
        end
    end

    assign rd_valid  = rd_valid_q;
    assign rd_dataA  = rd_data_q[0];
    assign rd_dataB  = rd_data_q[1];
    assign rd_dataC  = rd_data_q[2];
    assign rd_dataD  = rd_data_q[3];
    assign rd_last   = last;
    assign rd_index  = rd_index_q;
    assign row_count = row_count_q;
    assign done      = (state_q == DONE);
    assign overflow  = overflow_q;
    assign drop_err  = drop_err_q;

endmodule
